// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Purpose : Shared timing constants and helpers for the VGA timing engine.
//           Provides 640x480@60 and 800x600@60 timing sets, the host
//           colour width, and a helper that derives an axis' total length
//           and active-area origin from its sync/bp/act/fp lengths.
// Rev     : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int unsigned C_VGA_H_SYNC = 96;
  localparam int unsigned C_VGA_H_BP   = 48;
  localparam int unsigned C_VGA_H_ACT  = 640;
  localparam int unsigned C_VGA_H_FP   = 16;
  localparam int unsigned C_VGA_V_SYNC = 2;
  localparam int unsigned C_VGA_V_BP   = 33;
  localparam int unsigned C_VGA_V_ACT  = 480;
  localparam int unsigned C_VGA_V_FP   = 10;

  // 800x600 @ 60 Hz (40 MHz pixel clock)
  localparam int unsigned C_SVGA_H_SYNC = 128;
  localparam int unsigned C_SVGA_H_BP   = 88;
  localparam int unsigned C_SVGA_H_ACT  = 800;
  localparam int unsigned C_SVGA_H_FP   = 40;
  localparam int unsigned C_SVGA_V_SYNC = 4;
  localparam int unsigned C_SVGA_V_BP   = 23;
  localparam int unsigned C_SVGA_V_ACT  = 600;
  localparam int unsigned C_SVGA_V_FP   = 1;

  // Host colour channel width
  localparam int unsigned C_COLOR_W = 10;

  typedef struct packed {
    int unsigned total;  // full axis period
    int unsigned start;  // first active position
  } axis_geom_t;

  function automatic axis_geom_t axis_geom(input int unsigned sync,
                                           input int unsigned bp,
                                           input int unsigned act,
                                           input int unsigned fp);
    axis_geom_t g;
    g.total = sync + bp + act + fp;
    g.start = sync + bp;
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module  : vga_axis_counter
// Purpose : One timing axis (horizontal or vertical). Counts 0..TOT-1 while
//           enabled and wraps, and decodes sync level, active window and
//           origin from the current count.
// Ports   : i_clk, i_rst (async, active-high), i_en (advance enable)
//           o_cnt    current position
//           o_wrap   i_en while at the last position (count wraps this edge)
//           o_sync   sync line level with polarity applied
//           o_active position inside the active window
//           o_start  position is 0
// Rev     : 1.0  initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48,
  parameter int unsigned ACT  = 640,
  parameter int unsigned FP   = 16,
  parameter bit          POL  = 1'b0,
  localparam axis_geom_t  GEOM  = axis_geom(SYNC, BP, ACT, FP),
  // One spare code so START+ACT is representable even when FP = 0
  localparam int unsigned CNT_W = $clog2(GEOM.total + 1)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_sync,
  output logic             o_active,
  output logic             o_start
);

  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(GEOM.total - 1);
  localparam logic [CNT_W-1:0] C_SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] C_ACT_BEG  = CNT_W'(GEOM.start);
  localparam logic [CNT_W-1:0] C_ACT_END  = CNT_W'(GEOM.start + ACT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == C_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_wrap   = i_en & w_last;
  assign o_sync   = (r_cnt < C_SYNC_END) ? POL : ~POL;
  assign o_active = (r_cnt >= C_ACT_BEG) && (r_cnt < C_ACT_END);
  assign o_start  = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_engine
// Purpose : Parametrised VGA raster timing with pixel request strobe, draw
//           coordinates and a one-stage registered colour path (grayscale
//           and overlay modes) driving an ADV7123-style DAC.
// Ports   : iCLK / iRST (async, active-high) / iPIX_EN (advance enable)
//           iRed/iGreen/iBlue host pixel, iGRAY grayscale select,
//           iOverlay overlay hit for current DrawX/DrawY
//           oRequest pixel request (REQ_LEAD cycles ahead of data)
//           DrawX/DrawY active-area coordinates (0 outside active area)
//           oVGA_R/G/B, oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK (blank_n),
//           oVGA_SYNC (tied 0), oVGA_CLOCK (= iCLK)
//           oFrameStart / oLineStart origin pulses
// Rev     : 1.0  initial release
// ============================================================================
module vga_timing_engine
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = C_VGA_H_SYNC,
  parameter int unsigned H_BP     = C_VGA_H_BP,
  parameter int unsigned H_ACT    = C_VGA_H_ACT,
  parameter int unsigned H_FP     = C_VGA_H_FP,
  parameter int unsigned V_SYNC   = C_VGA_V_SYNC,
  parameter int unsigned V_BP     = C_VGA_V_BP,
  parameter int unsigned V_ACT    = C_VGA_V_ACT,
  parameter int unsigned V_FP     = C_VGA_V_FP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned COLOR_W  = C_COLOR_W,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned REQ_LEAD = 1,
  parameter logic [COLOR_W-1:0] OVL_R = '1,
  parameter logic [COLOR_W-1:0] OVL_G = '0,
  parameter logic [COLOR_W-1:0] OVL_B = '0,
  localparam int unsigned DX_W = $clog2(H_ACT),
  localparam int unsigned DY_W = $clog2(V_ACT)
)(
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iPIX_EN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  input  logic               iGRAY,
  input  logic               iOverlay,
  output logic               oRequest,
  output logic [DX_W-1:0]    DrawX,
  output logic [DY_W-1:0]    DrawY,
  output logic [OUT_W-1:0]   oVGA_R,
  output logic [OUT_W-1:0]   oVGA_G,
  output logic [OUT_W-1:0]   oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic               oFrameStart,
  output logic               oLineStart
);

  localparam axis_geom_t  H_GEOM = axis_geom(H_SYNC, H_BP, H_ACT, H_FP);
  localparam axis_geom_t  V_GEOM = axis_geom(V_SYNC, V_BP, V_ACT, V_FP);
  localparam int unsigned H_CW   = $clog2(H_GEOM.total + 1);
  localparam int unsigned V_CW   = $clog2(V_GEOM.total + 1);

  localparam logic [H_CW-1:0] C_H_START = H_CW'(H_GEOM.start);
  localparam logic [V_CW-1:0] C_V_START = V_CW'(V_GEOM.start);
  // Request window, expressed on the h value the counter is about to take
  localparam logic [H_CW-1:0] C_REQ_BEG = H_CW'(H_GEOM.start - REQ_LEAD);
  localparam logic [H_CW-1:0] C_REQ_END = H_CW'(H_GEOM.start + H_ACT - REQ_LEAD);

  logic [H_CW-1:0] w_h, w_h_nxt;
  logic [V_CW-1:0] w_v;
  logic            w_h_wrap, w_v_wrap;
  logic            w_h_sync, w_v_sync;
  logic            w_h_act, w_v_act, w_act;
  logic            w_h_start, w_v_start;
  logic            w_unused;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .POL(H_POL)
  ) u_h_axis (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_en    (iPIX_EN),
    .o_cnt   (w_h),
    .o_wrap  (w_h_wrap),
    .o_sync  (w_h_sync),
    .o_active(w_h_act),
    .o_start (w_h_start)
  );

  // Vertical axis advances once per completed line
  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .POL(V_POL)
  ) u_v_axis (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_en    (w_h_wrap),
    .o_cnt   (w_v),
    .o_wrap  (w_v_wrap),
    .o_sync  (w_v_sync),
    .o_active(w_v_act),
    .o_start (w_v_start)
  );

  assign w_unused = w_v_wrap;
  assign w_act    = w_h_act & w_v_act;
  // Only consumed on enabled edges, where w_h_wrap equals "h is last"
  assign w_h_nxt  = w_h_wrap ? '0 : w_h + H_CW'(1);

  assign DrawX = w_act ? DX_W'(w_h - C_H_START) : '0;
  assign DrawY = w_act ? DY_W'(w_v - C_V_START) : '0;

  // Colour selection: overlay > grayscale > pass-through
  logic [COLOR_W+1:0] w_sum;
  logic [COLOR_W-1:0] w_gray;
  logic [COLOR_W-1:0] w_r, w_g, w_b;

  assign w_sum  = {2'b00, iRed} + {1'b0, iGreen, 1'b0} + {2'b00, iBlue};
  assign w_gray = w_sum[COLOR_W+1:2];

  always_comb begin
    w_r = iRed;
    w_g = iGreen;
    w_b = iBlue;
    if (iGRAY) begin
      w_r = w_gray;
      w_g = w_gray;
      w_b = w_gray;
    end
    if (iOverlay) begin
      w_r = OVL_R;
      w_g = OVL_G;
      w_b = OVL_B;
    end
  end

  logic               r_req, r_hs, r_vs, r_blank, r_frame, r_line;
  logic [OUT_W-1:0]   r_red, r_grn, r_blu;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_req   <= 1'b0;
      r_hs    <= ~H_POL;
      r_vs    <= ~V_POL;
      r_blank <= 1'b0;
      r_frame <= 1'b0;
      r_line  <= 1'b0;
      r_red   <= '0;
      r_grn   <= '0;
      r_blu   <= '0;
    end else if (iPIX_EN) begin
      // v cannot change between a request-window h and its predecessor
      // because the window never contains h = 0.
      r_req   <= w_v_act && (w_h_nxt >= C_REQ_BEG) && (w_h_nxt < C_REQ_END);
      r_hs    <= w_h_sync;
      r_vs    <= w_v_sync;
      r_blank <= w_act;
      r_frame <= w_h_start & w_v_start;
      r_line  <= w_h_start;
      r_red   <= w_act ? w_r[COLOR_W-1 -: OUT_W] : '0;
      r_grn   <= w_act ? w_g[COLOR_W-1 -: OUT_W] : '0;
      r_blu   <= w_act ? w_b[COLOR_W-1 -: OUT_W] : '0;
    end
  end

  assign oRequest    = r_req;
  assign oVGA_R      = r_red;
  assign oVGA_G      = r_grn;
  assign oVGA_B      = r_blu;
  assign oVGA_H_SYNC = r_hs;
  assign oVGA_V_SYNC = r_vs;
  assign oVGA_BLANK  = r_blank;
  assign oFrameStart = r_frame;
  assign oLineStart  = r_line;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_CLOCK  = iCLK;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_vga_timing_engine
// Purpose : Self-checking bench. Two engines on a reduced raster share the
//           same stimulus: A (REQ_LEAD=1, active-low syncs) and B
//           (REQ_LEAD=3, active-high syncs). Expected values come from the
//           count of enabled edges since reset: position = n mod H_TOT etc.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_timing_engine;

  localparam int HS = 4, HB = 3, HA = 10, HF = 2;
  localparam int VS = 2, VB = 2, VA = 6,  VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int XS = HS + HB;
  localparam int YS = VS + VB;
  localparam int CW = 10, OW = 8;

  logic          clk = 1'b0;
  logic          rst, en, gray, ovl;
  logic [CW-1:0] r, g, b;

  logic          a_req, a_hs, a_vs, a_blank, a_sync, a_clk, a_fs, a_ls;
  logic [3:0]    a_dx;
  logic [2:0]    a_dy;
  logic [OW-1:0] a_r, a_g, a_b;
  logic          b_req, b_hs, b_vs, b_blank, b_sync, b_clk, b_fs, b_ls;
  logic [3:0]    b_dx;
  logic [2:0]    b_dy;
  logic [OW-1:0] b_r, b_g, b_b;

  always #5 clk = ~clk;

  vga_timing_engine #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(CW), .OUT_W(OW), .REQ_LEAD(1)
  ) u_dut_a (
    .iCLK(clk), .iRST(rst), .iPIX_EN(en),
    .iRed(r), .iGreen(g), .iBlue(b), .iGRAY(gray), .iOverlay(ovl),
    .oRequest(a_req), .DrawX(a_dx), .DrawY(a_dy),
    .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
    .oVGA_H_SYNC(a_hs), .oVGA_V_SYNC(a_vs), .oVGA_BLANK(a_blank),
    .oVGA_SYNC(a_sync), .oVGA_CLOCK(a_clk),
    .oFrameStart(a_fs), .oLineStart(a_ls)
  );

  vga_timing_engine #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(CW), .OUT_W(OW), .REQ_LEAD(3)
  ) u_dut_b (
    .iCLK(clk), .iRST(rst), .iPIX_EN(en),
    .iRed(r), .iGreen(g), .iBlue(b), .iGRAY(gray), .iOverlay(ovl),
    .oRequest(b_req), .DrawX(b_dx), .DrawY(b_dy),
    .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oVGA_H_SYNC(b_hs), .oVGA_V_SYNC(b_vs), .oVGA_BLANK(b_blank),
    .oVGA_SYNC(b_sync), .oVGA_CLOCK(b_clk),
    .oFrameStart(b_fs), .oLineStart(b_ls)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_en  = 0;                 // enabled edges since reset release
  logic [CW-1:0] cr, cg, cb;     // inputs seen at the last enabled edge
  logic          cgray, covl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", tag, got, exp, n_en, $time);
    end
  endtask

  function automatic int hpos(input int n); return n % HT; endfunction
  function automatic int vpos(input int n); return (n / HT) % VT; endfunction
  function automatic bit in_act(input int h, input int v);
    return (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
  endfunction
  function automatic bit req_exp(input int h, input int v, input int lead);
    return (v >= YS) && (v < YS + VA) && (h >= XS - lead) && (h < XS + HA - lead);
  endfunction
  // sel: 0=R 1=G 2=B
  function automatic int exp_col(input int sel, input bit act);
    int c;
    if (!act) return 0;
    if (covl) return (sel == 0) ? 255 : 0;
    if (cgray) c = (int'(cr) + 2 * int'(cg) + int'(cb)) / 4;
    else c = (sel == 0) ? int'(cr) : (sel == 1) ? int'(cg) : int'(cb);
    return c / (1 << (CW - OW));
  endfunction

  task automatic check_all();
    int h1, v1, h0, v0;
    bit act0, act1, hsa, vsa;
    h1 = hpos(n_en); v1 = vpos(n_en);
    act1 = in_act(h1, v1);
    chk("a_drawx", 32'(a_dx), act1 ? h1 - XS : 0);
    chk("b_drawx", 32'(b_dx), act1 ? h1 - XS : 0);
    chk("a_drawy", 32'(a_dy), act1 ? v1 - YS : 0);
    chk("b_drawy", 32'(b_dy), act1 ? v1 - YS : 0);
    chk("a_req", 32'(a_req), 32'(req_exp(h1, v1, 1)));
    chk("b_req", 32'(b_req), 32'(req_exp(h1, v1, 3)));
    chk("a_vga_sync", 32'(a_sync), 0);
    chk("a_vga_clock", 32'(a_clk), 32'(clk));
    if (n_en == 0) begin
      chk("a_hs_rst", 32'(a_hs), 1);  chk("b_hs_rst", 32'(b_hs), 0);
      chk("a_vs_rst", 32'(a_vs), 1);  chk("b_vs_rst", 32'(b_vs), 0);
      chk("a_blank_rst", 32'(a_blank), 0);
      chk("a_fs_rst", 32'(a_fs), 0);  chk("a_ls_rst", 32'(a_ls), 0);
      chk("a_rgb_rst", {8'h0, a_r, a_g, a_b}, 0);
      chk("b_rgb_rst", {8'h0, b_r, b_g, b_b}, 0);
    end else begin
      h0 = hpos(n_en - 1); v0 = vpos(n_en - 1);
      act0 = in_act(h0, v0);
      hsa = (h0 < HS); vsa = (v0 < VS);
      chk("a_hsync", 32'(a_hs), 32'(!hsa)); chk("b_hsync", 32'(b_hs), 32'(hsa));
      chk("a_vsync", 32'(a_vs), 32'(!vsa)); chk("b_vsync", 32'(b_vs), 32'(vsa));
      chk("a_blank", 32'(a_blank), 32'(act0));
      chk("b_blank", 32'(b_blank), 32'(act0));
      chk("a_frame", 32'(a_fs), 32'(h0 == 0 && v0 == 0));
      chk("b_frame", 32'(b_fs), 32'(h0 == 0 && v0 == 0));
      chk("a_line", 32'(a_ls), 32'(h0 == 0));
      chk("a_red", 32'(a_r), exp_col(0, act0));
      chk("a_grn", 32'(a_g), exp_col(1, act0));
      chk("a_blu", 32'(a_b), exp_col(2, act0));
      chk("b_rgb", {8'h0, b_r, b_g, b_b},
          32'((exp_col(0, act0) << 16) | (exp_col(1, act0) << 8) | exp_col(2, act0)));
    end
  endtask

  // mode 0: random; 1: R full, gray on; 2: R full, gray off;
  // 3: random colour, gray on, overlay only at draw (3,2)
  task automatic drive(input bit e, input int mode);
    int h, v;
    en = e;
    h = hpos(n_en); v = vpos(n_en);
    case (mode)
      1, 2: begin
        r = 10'h3FF; g = '0; b = '0; gray = (mode == 1); ovl = 1'b0;
      end
      3: begin
        r = CW'($urandom); g = CW'($urandom); b = CW'($urandom); gray = 1'b1;
        ovl = in_act(h, v) && (h - XS == 3) && (v - YS == 2);
      end
      default: begin
        r = CW'($urandom); g = CW'($urandom); b = CW'($urandom);
        gray = 1'($urandom); ovl = ($urandom_range(0, 7) == 0);
      end
    endcase
  endtask

  task automatic step(input bit e, input int mode);
    @(posedge clk);
    #1;
    if (!rst && en) begin
      n_en++;
      cr = r; cg = g; cb = b; cgray = gray; covl = ovl;
    end
    check_all();
    drive(e, mode);
  endtask

  initial begin
    int guard;
    rst = 1'b1; cr = '0; cg = '0; cb = '0; cgray = 1'b0; covl = 1'b0;
    drive(1'b0, 0);
    repeat (3) step(1'b0, 0);
    drive(1'b1, 0);
    @(negedge clk) rst = 1'b0;

    repeat (2 * HT * VT) step(1'b1, 0);           // free-running, random data
    for (int i = 0; i < 4 * HT * VT; i++) step(1'(i % 2), 0);  // 50% enable
    repeat (HT * VT) step(1'b1, 1);               // gray of full red
    repeat (HT * VT) step(1'b1, 2);               // pass-through full red
    repeat (HT * VT) step(1'b1, 3);               // single overlay pixel
    repeat (HT * VT) step(1'($urandom_range(0, 3) != 0), 0);

    // Mid-frame asynchronous reset at h=9, v=4
    guard = 0;
    while (!(hpos(n_en) == 9 && vpos(n_en) == 4) && guard < 2 * HT * VT) begin
      step(1'b1, 0);
      guard++;
    end
    chk("rst_target_reached", 32'(guard < 2 * HT * VT), 1);
    #2;
    rst = 1'b1;
    n_en = 0;
    #1;
    check_all();
    repeat (3) step(1'b1, 0);
    @(negedge clk) rst = 1'b0;
    repeat (HT * VT + 5) step(1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_engine.md
Name: vga_timing_engine

Overview:
Parametrised successor to the board's fixed 640x480 VGA controller. It generates H/V sync, blank, and a pixel-request strobe for the upstream frame buffer or camera FIFO. It drives pixel-aligned draw coordinates for overlay logic and outputs registered colour with optional grayscale and overlay modes. It sits between the SDRAM/FIFO read side and the ADV7123 DAC pins, in the VGA clock domain.

Parameters:
H_SYNC, 96, horizontal sync width (pixel clocks)
H_BP, 48, horizontal back porch
H_ACT, 640, horizontal active pixels
H_FP, 16, horizontal front porch
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch
V_ACT, 480, vertical active lines
V_FP, 10, vertical front porch
H_POL, 0, active sync level for H (0 = active-low)
V_POL, 0, active sync level for V
COLOR_W, 10, host colour channel width
OUT_W, 8, DAC channel width; must satisfy OUT_W <= COLOR_W
REQ_LEAD, 1, cycles between oRequest and the host's data presentation (1..4)
OVL_R / OVL_G / OVL_B, all-ones / 0 / 0, overlay colour (COLOR_W each)

Ports:
iCLK  in  1  pixel clock
iRST  in  1  asynchronous active-high reset
iPIX_EN  in  1  pixel-clock enable; all state advances only when high
iRed / iGreen / iBlue  in  COLOR_W each  host pixel
iGRAY  in  1  grayscale mode select, sampled per pixel
iOverlay  in  1  overlay hit for the current DrawX/DrawY (e.g. ball)
oRequest  out  1  pixel request to host
DrawX  out  clog2(H_ACT)  active-area column
DrawY  out  clog2(V_ACT)  active-area row
oVGA_R / oVGA_G / oVGA_B  out  OUT_W each  DAC colour
oVGA_H_SYNC  out  1  horizontal sync
oVGA_V_SYNC  out  1  vertical sync
oVGA_BLANK  out  1  high during active video; DAC blank_n
oVGA_SYNC  out  1  constant 0
oVGA_CLOCK  out  1  equals iCLK
oFrameStart  out  1  one-enable-cycle pulse at frame origin
oLineStart  out  1  one-enable-cycle pulse at each line origin

Behaviour:
- Totals and active origin:
  - H_TOT = H_SYNC + H_BP + H_ACT + H_FP; V_TOT likewise.
  - X_START = H_SYNC + H_BP; Y_START = V_SYNC + V_BP.
- Counters:
  - h counts 0..H_TOT-1 and wraps to 0. This fixes the predecessor's TOTAL+1 overcount.
  - v increments when h wraps, counts 0..V_TOT-1, and wraps to 0.
  - Nothing changes on cycles where iPIX_EN = 0; all registered outputs hold.
- Active region: hact = X_START <= h < X_START+H_ACT; vact = Y_START <= v < Y_START+V_ACT; act = hact & vact.
- Request and data timing:
  - oRequest is registered and is high in the cycle where vact holds and h is in [X_START-REQ_LEAD, X_START+H_ACT-REQ_LEAD).
  - For pixel k, the host presents data while h = X_START+k. Exactly H_ACT requests are issued per active line and none on blank lines.
- DrawX/DrawY:
  - Combinational: DrawX = h - X_START and DrawY = v - Y_START when act, else 0.
  - iOverlay is sampled in the same cycle as the host data.
- Colour path (one register stage):
  - If iGRAY, gray = (R + 2G + B) >> 2, computed at COLOR_W+2 bits with no overflow; otherwise per-channel colour is used.
  - Overlay has priority over grayscale and substitutes OVL_* directly.
  - The output takes the top OUT_W bits [COLOR_W-1 -: OUT_W] when act, else 0.
- Output alignment:
  - oVGA_H_SYNC is active (level = H_POL) for h < H_SYNC; oVGA_V_SYNC is active for v < V_SYNC.
  - oVGA_BLANK = act.
  - Syncs, blank, colour, oFrameStart (h=0 & v=0) and oLineStart (h=0) are all registered from the same counter value. They therefore appear one enabled cycle after that counter value and stay mutually aligned.
- Reset (asynchronous, any time):
  - h = v = 0.
  - Syncs go to the inactive level (~H_POL / ~V_POL).
  - oVGA_BLANK, colours, oRequest, oFrameStart and oLineStart go to 0.
  - After release, the first enabled cycle evaluates (0,0), so oFrameStart pulses on the next enabled cycle.
  - Reset mid-line aborts the line; the host FIFO must be flushed externally.
- Simultaneous events: at h = H_TOT-1 with v = V_TOT-1, both counters wrap in the same cycle.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 timing constants;
  - an SVGA 800x600 constant set;
  - a function returning total and start from sync/bp/act/fp;
  - a colour-width localparam.
- Sub-module vga_axis_counter (counter, wrap, sync, active, start pulse per axis) is instantiated twice. The H instance's wrap serves as the V instance's enable.

Test Plan:
1. Defaults, iPIX_EN=1, reset released -> oFrameStart pulses on the 1st cycle. Period is 800 cycles per line and 420000 per frame. H sync is low for 96 cycles and V sync is low for 1600 cycles.
2. Count oRequest over one frame, REQ_LEAD=1 and then 3 -> 640 per line and 307200 per frame. First request at h=143 (REQ_LEAD=1) or h=141 (REQ_LEAD=3), v=35.
3. Drive iRed = 10'h3FF, G = B = 0, iGRAY=1 -> oVGA_R = G = B = 8'h3F. With iGRAY=0, oVGA_R=8'hFF. Outside the active area, all outputs are 0.
4. Drive iOverlay=1 at DrawX=100, DrawY=50 with gray mode on -> exactly that pixel outputs R=FF, G=00, B=00 one cycle later.
5. Toggle iPIX_EN at 50% -> all timing stretches exactly 2x and no output changes on disabled cycles.
6. Assert iRST at h=400, v=200 -> outputs take reset values immediately and, after release, the frame restarts at (0,0).
